// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types used by the memory-access stage.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    // Memory-access sequencer states; FIRST/SECOND are the two possible
    // data-memory transactions (SECOND only used by LDI/STI).
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2,
        DONE   = 2'd3
    } lc3b_mem_state;

endpackage

// File: rtl/mem_byte_align.sv
// Byte-lane steering for data-memory accesses: byte enables, store-data
// replication and load-result extraction. Purely combinational.
module mem_byte_align
    import lc3b_types::*;
(
    input  logic       byte_mode,
    input  logic       addr_lsb,
    input  lc3b_word   store_data,
    input  lc3b_word   rdata,
    output logic [1:0] byte_enable,
    output lc3b_word   wdata,
    output lc3b_word   load_data
);

    // Word accesses use both lanes untouched; byte accesses pick one lane
    // and replicate the low store byte so either lane sees it.
    always_comb begin
        byte_enable = 2'b11;
        wdata       = store_data;
        load_data   = rdata;
        if (byte_mode) begin
            byte_enable = addr_lsb ? 2'b10 : 2'b01;
            wdata       = {store_data[7:0], store_data[7:0]};
            load_data   = addr_lsb ? {8'h00, rdata[15:8]} : {8'h00, rdata[7:0]};
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// LC-3b MEM stage controller: sequences data memory for LDR/STR/LDB/STB
// and the two-transaction LDI/STI, stalling the pipeline while busy.
module mem_access_stage
    import lc3b_types::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic        is_ldi_in,
    input  logic        is_sti_in,
    input  logic        is_ldb_stb_in,
    input  logic [15:0] mem_addr_in,
    input  logic [15:0] store_data_in,
    output logic [15:0] dmem_address,
    output logic [15:0] dmem_wdata,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [1:0]  dmem_byte_enable,
    input  logic [15:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic [15:0] mem_rdata_out,
    output logic        stall_pipeline
);

    lc3b_mem_state state_q, state_d;
    lc3b_word      ptr_q, ptr_d;
    lc3b_word      data_q, data_d;
    lc3b_word      addr_raw;
    lc3b_word      load_data;
    logic          req;
    logic          byte_mode;
    logic          indirect;

    assign req      = mem_read_in | mem_write_in;
    assign indirect = is_ldi_in | is_sti_in;
    // Pointer fetch and pointer target are always word accesses.
    assign byte_mode = (state_q == FIRST) & is_ldb_stb_in;
    assign addr_raw  = (state_q == SECOND) ? ptr_q : mem_addr_in;

    // Word accesses are forced to an even address.
    always_comb begin
        dmem_address = byte_mode ? addr_raw : {addr_raw[15:1], 1'b0};
    end

    mem_byte_align u_align (
        .byte_mode   (byte_mode),
        .addr_lsb    (addr_raw[0]),
        .store_data  (store_data_in),
        .rdata       (dmem_rdata),
        .byte_enable (dmem_byte_enable),
        .wdata       (dmem_wdata),
        .load_data   (load_data)
    );

    // Next-state, strobes, stall and result/pointer capture.
    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        data_d         = data_q;
        dmem_read      = 1'b0;
        dmem_write     = 1'b0;
        stall_pipeline = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    stall_pipeline = 1'b1;
                    state_d        = FIRST;
                end
            end
            FIRST: begin
                stall_pipeline = 1'b1;
                // STI first reads the pointer, so it is a read here.
                dmem_read  = mem_read_in | is_sti_in;
                dmem_write = mem_write_in & ~is_sti_in;
                if (dmem_resp) begin
                    if (indirect) begin
                        ptr_d   = dmem_rdata;
                        state_d = SECOND;
                    end else begin
                        // Stores leave the previous load result in place.
                        if (mem_read_in) data_d = load_data;
                        state_d = DONE;
                    end
                end
            end
            SECOND: begin
                stall_pipeline = 1'b1;
                dmem_read      = is_ldi_in;
                dmem_write     = is_sti_in;
                if (dmem_resp) begin
                    if (is_ldi_in) data_d = load_data;
                    state_d = DONE;
                end
            end
            DONE: begin
                // Pipeline advances on this edge; return to IDLE regardless.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, pointer and load-result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
        end
    end

    assign mem_rdata_out = data_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a behavioural memory responder.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read_in, mem_write_in, is_ldi_in, is_sti_in, is_ldb_stb_in;
    logic [15:0] mem_addr_in, store_data_in;
    logic [15:0] dmem_address, dmem_wdata, dmem_rdata, mem_rdata_out;
    logic        dmem_read, dmem_write, dmem_resp, stall_pipeline;
    logic [1:0]  dmem_byte_enable;

    int checks = 0;
    int failures = 0;

    // Per-transaction snapshot taken on the first strobed cycle.
    logic [15:0] cap_addr [2];
    logic [15:0] cap_wd   [2];
    logic [1:0]  cap_be   [2];
    logic        cap_rd   [2];
    logic        cap_wr   [2];
    int          stalls;
    int          unstable;
    int          timed_out;

    mem_access_stage dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .mem_read_in      (mem_read_in),
        .mem_write_in     (mem_write_in),
        .is_ldi_in        (is_ldi_in),
        .is_sti_in        (is_sti_in),
        .is_ldb_stb_in    (is_ldb_stb_in),
        .mem_addr_in      (mem_addr_in),
        .store_data_in    (store_data_in),
        .dmem_address     (dmem_address),
        .dmem_wdata       (dmem_wdata),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_byte_enable (dmem_byte_enable),
        .dmem_rdata       (dmem_rdata),
        .dmem_resp        (dmem_resp),
        .mem_rdata_out    (mem_rdata_out),
        .stall_pipeline   (stall_pipeline)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic rd, input logic wr, input logic ldi, input logic sti,
                             input logic bt, input logic [15:0] addr, input logic [15:0] sd);
        mem_read_in   = rd;
        mem_write_in  = wr;
        is_ldi_in     = ldi;
        is_sti_in     = sti;
        is_ldb_stb_in = bt;
        mem_addr_in   = addr;
        store_data_in = sd;
    endtask

    // Drive one instruction from IDLE until the stall drops (DONE, or
    // immediately for a non-memory op). Memory answers on the lat-th
    // strobed cycle of each transaction with r1 then r2.
    task automatic run(input logic rd, input logic wr, input logic ldi, input logic sti,
                       input logic bt, input logic [15:0] addr, input logic [15:0] sd,
                       input int lat, input logic [15:0] r1, input logic [15:0] r2);
        int w, nresp;
        logic done;
        w = 0; nresp = 0; stalls = 0; unstable = 0; done = 1'b0; timed_out = 0;
        set_instr(rd, wr, ldi, sti, bt, addr, sd);
        #1;
        for (int c = 0; c < 60 && !done; c++) begin
            dmem_resp = 1'b0;
            if (!stall_pipeline) begin
                done = 1'b1;
            end else begin
                stalls++;
                if (dmem_read || dmem_write) begin
                    if (w == 0 && nresp < 2) begin
                        cap_addr[nresp] = dmem_address;
                        cap_wd[nresp]   = dmem_wdata;
                        cap_be[nresp]   = dmem_byte_enable;
                        cap_rd[nresp]   = dmem_read;
                        cap_wr[nresp]   = dmem_write;
                    end else if (nresp < 2) begin
                        if (cap_addr[nresp] !== dmem_address || cap_rd[nresp] !== dmem_read ||
                            cap_wr[nresp] !== dmem_write || cap_be[nresp] !== dmem_byte_enable)
                            unstable++;
                    end
                    w++;
                    if (w >= lat) begin
                        dmem_resp  = 1'b1;
                        dmem_rdata = (nresp == 0) ? r1 : r2;
                        nresp++;
                        w = 0;
                    end
                end
                step();
            end
        end
        dmem_resp = 1'b0;
        if (!done) timed_out = 1;
    endtask

    task automatic go_idle();
        set_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        dmem_resp = 1'b0;
        dmem_rdata = 16'h0;
        set_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        #1;
        chk("rst_stall", stall_pipeline, 0);
        chk("rst_strobes", {dmem_read, dmem_write}, 0);
        chk("rst_rdata", mem_rdata_out, 16'h0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // ADD: no request, no stall, no strobes.
        run(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h0, 1, 16'h0, 16'h0);
        chk("add_stall", stalls, 0);
        chk("add_strobes", {dmem_read, dmem_write}, 0);
        chk("add_to", timed_out, 0);

        // LDR 0x1003 -> word aligned 0x1002.
        run(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1003, 16'h0, 1, 16'hBEEF, 16'h0);
        chk("ldr_to", timed_out, 0);
        chk("ldr_stall", stalls, 2);
        chk("ldr_addr", cap_addr[0], 16'h1002);
        chk("ldr_be", cap_be[0], 2'b11);
        chk("ldr_rdwr", {cap_rd[0], cap_wr[0]}, 2'b10);
        chk("ldr_data", mem_rdata_out, 16'hBEEF);
        chk("ldr_done_strobes", {dmem_read, dmem_write}, 0);
        go_idle();

        // LDB odd / even.
        run(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h2001, 16'h0, 1, 16'hA55A, 16'h0);
        chk("ldb1_be", cap_be[0], 2'b10);
        chk("ldb1_addr", cap_addr[0], 16'h2001);
        chk("ldb1_data", mem_rdata_out, 16'h00A5);
        go_idle();
        run(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h2000, 16'h0, 1, 16'hA55A, 16'h0);
        chk("ldb0_be", cap_be[0], 2'b01);
        chk("ldb0_data", mem_rdata_out, 16'h005A);
        go_idle();

        // STB odd: replicated data, load result untouched.
        run(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h3001, 16'h1234, 1, 16'hFFFF, 16'h0);
        chk("stb_rdwr", {cap_rd[0], cap_wr[0]}, 2'b01);
        chk("stb_be", cap_be[0], 2'b10);
        chk("stb_wdata", cap_wd[0], 16'h3434);
        chk("stb_hold", mem_rdata_out, 16'h005A);
        go_idle();

        // LDI 0x4000 -> ptr 0x5000 -> 0x0042.
        run(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h4000, 16'h0, 1, 16'h5000, 16'h0042);
        chk("ldi_stall", stalls, 3);
        chk("ldi_addr1", cap_addr[0], 16'h4000);
        chk("ldi_addr2", cap_addr[1], 16'h5000);
        chk("ldi_rd2", {cap_rd[1], cap_wr[1]}, 2'b10);
        chk("ldi_data", mem_rdata_out, 16'h0042);
        go_idle();

        // STI 0x4002 -> ptr 0x6001 (word-aligned to 0x6000), writes 0xCAFE.
        run(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h4002, 16'hCAFE, 1, 16'h6001, 16'h0);
        chk("sti_stall", stalls, 3);
        chk("sti_rdwr1", {cap_rd[0], cap_wr[0]}, 2'b10);
        chk("sti_addr2", cap_addr[1], 16'h6000);
        chk("sti_rdwr2", {cap_rd[1], cap_wr[1]}, 2'b01);
        chk("sti_wdata", cap_wd[1], 16'hCAFE);
        chk("sti_be2", cap_be[1], 2'b11);
        chk("sti_hold", mem_rdata_out, 16'h0042);
        go_idle();

        // LDR with response on the 4th FIRST cycle.
        run(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0777, 16'h0, 4, 16'h1357, 16'h0);
        chk("wait_stall", stalls, 5);
        chk("wait_stable", unstable, 0);
        chk("wait_data", mem_rdata_out, 16'h1357);

        // Back-to-back: STR presented during DONE.
        set_instr(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0800, 16'h9999);
        #1;
        chk("b2b_done_stall", stall_pipeline, 0);
        step();
        chk("b2b_idle_stall", stall_pipeline, 1);
        chk("b2b_idle_strobes", {dmem_read, dmem_write}, 0);
        run(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0800, 16'h9999, 1, 16'h0, 16'h0);
        chk("b2b_str_stall", stalls, 2);
        chk("b2b_str_wdata", cap_wd[0], 16'h9999);
        go_idle();

        // Reset during SECOND of an LDI.
        set_instr(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h4000, 16'h0);
        step();
        dmem_resp = 1'b1;
        dmem_rdata = 16'h5000;
        step();
        dmem_resp = 1'b0;
        chk("rstmid_second_addr", dmem_address, 16'h5000);
        chk("rstmid_second_rd", dmem_read, 1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_strobes", {dmem_read, dmem_write}, 0);
        chk("rstmid_rdata", mem_rdata_out, 16'h0);
        set_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        #1;
        chk("rstmid_stall", stall_pipeline, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("rstmid_idle", {stall_pipeline, dmem_read, dmem_write}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
